// File: rtl/cache_assoc.sv
// ============================================================================
// cache_assoc : blocking write-back / write-allocate set-associative cache with
// tree-pLRU replacement. CACHE_ASSOC_PERF_CNT_EN builds hit/miss counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_assoc #(
  parameter int NUM_WAYS   = 2,
  parameter int NUM_SETS   = 8,
  parameter int LINE_BYTES = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_read,
  input  logic                      mem_write,
  input  logic [1:0]                mem_byte_enable,
  input  logic [15:0]               mem_address,
  input  logic [15:0]               mem_wdata,
  output logic [15:0]               mem_rdata,
  output logic                      mem_resp,
  output logic                      pmem_read,
  output logic                      pmem_write,
  output logic [15:0]               pmem_address,
  output logic [8*LINE_BYTES-1:0]   pmem_wdata,
  input  logic [8*LINE_BYTES-1:0]   pmem_rdata,
  input  logic                      pmem_resp,
  output logic [15:0]               perf_hits,
  output logic [15:0]               perf_misses
);

  localparam int OFS       = $clog2(LINE_BYTES);
  localparam int IDX       = $clog2(NUM_SETS);
  localparam int TAG       = 16 - OFS - IDX;
  localparam int LINE_BITS = 8 * LINE_BYTES;
  localparam int WAYW      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int PLRU      = (NUM_WAYS > 1) ? NUM_WAYS - 1 : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WB   = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  logic [1:0]                        state_q, state_d;
  logic [NUM_WAYS-1:0][NUM_SETS-1:0] valid_q, dirty_q;
  logic [TAG-1:0]                    tag_q  [NUM_WAYS][NUM_SETS];
  logic [LINE_BITS-1:0]              data_q [NUM_WAYS][NUM_SETS];
  logic [NUM_SETS-1:0][PLRU-1:0]     plru_q;
  logic [WAYW-1:0]                   victim_q;
  logic [15:OFS]                     addr_q;

  logic [TAG-1:0]       req_tag, fill_tag;
  logic [IDX-1:0]       req_idx, fill_idx;
  logic [OFS-2:0]       req_word;
  logic                 req, hit, hit_ok, wr_hit, fill_we, wb_done, miss_start;
  logic [WAYW-1:0]      hit_way, victim, plru_vict;
  logic [PLRU-1:0]      plru_cur, plru_new;
  logic [LINE_BITS-1:0] hit_line, merged;
  logic [15:0]          rd_word;
  logic                 unused_addr0;

  assign req_tag      = mem_address[15:OFS+IDX];
  assign req_idx      = mem_address[OFS+IDX-1:OFS];
  assign req_word     = mem_address[OFS-1:1];
  assign fill_tag     = addr_q[15:OFS+IDX];
  assign fill_idx     = addr_q[OFS+IDX-1:OFS];
  assign req          = mem_read | mem_write;
  assign unused_addr0 = mem_address[0];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAYW'(w);
      end
    end
  end

  assign hit_line = data_q[hit_way][req_idx];
  assign rd_word  = hit_line[{req_word, 4'h0} +: 16];
  assign plru_cur = plru_q[req_idx];

  always_comb begin
    merged = hit_line;
    if (mem_byte_enable[0]) merged[{req_word, 4'h0} +: 8] = mem_wdata[7:0];
    if (mem_byte_enable[1]) merged[{req_word, 4'h8} +: 8] = mem_wdata[15:8];
  end

  // Tree bits point at the next victim; an access flips the path away from it.
  if (NUM_WAYS == 4) begin : g_plru4
    assign plru_vict = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
    always_comb begin
      plru_new    = plru_cur;
      plru_new[0] = ~hit_way[1];
      if (hit_way[1]) plru_new[2] = ~hit_way[0];
      else            plru_new[1] = ~hit_way[0];
    end
  end else if (NUM_WAYS == 2) begin : g_plru2
    assign plru_vict = plru_cur[0];
    assign plru_new  = ~hit_way;
  end else begin : g_plru1
    assign plru_vict = 1'b0;
    assign plru_new  = 1'b0;
  end

  // Lowest-index invalid way wins over the pLRU choice.
  always_comb begin
    victim = plru_vict;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_idx]) victim = WAYW'(w);
    end
  end

  assign hit_ok  = (state_q == S_IDLE) && req && hit;
  assign wr_hit  = hit_ok && mem_write && (mem_byte_enable != 2'b00);
  assign fill_we = (state_q == S_FILL) && pmem_resp;
  assign wb_done = (state_q == S_WB) && pmem_resp;

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    miss_start   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            if (!mem_write) mem_rdata = rd_word;
          end else begin
            miss_start = 1'b1;
            state_d    = (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) ? S_WB : S_FILL;
          end
        end
      end
      S_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[victim_q][fill_idx], fill_idx, {OFS{1'b0}}};
        pmem_wdata   = data_q[victim_q][fill_idx];
        if (pmem_resp) state_d = S_FILL;
      end
      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {addr_q, {OFS{1'b0}}};
        if (pmem_resp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      plru_q   <= '0;
      victim_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (miss_start) begin
        victim_q <= victim;
        addr_q   <= mem_address[15:OFS];
      end
      if (hit_ok) plru_q[req_idx] <= plru_new;
      if (wr_hit) dirty_q[hit_way][req_idx] <= 1'b1;
      if (wb_done) dirty_q[victim_q][fill_idx] <= 1'b0;
      if (fill_we) begin
        valid_q[victim_q][fill_idx] <= 1'b1;
        dirty_q[victim_q][fill_idx] <= 1'b0;
      end
    end
  end

  // Tag/data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fill_we) begin
        tag_q[victim_q][fill_idx]  <= fill_tag;
        data_q[victim_q][fill_idx] <= pmem_rdata;
      end else if (wr_hit) begin
        data_q[hit_way][req_idx] <= merged;
      end
    end
  end

`ifdef CACHE_ASSOC_PERF_CNT_EN
  logic [15:0] hits_q, misses_q;
  logic        refill_q;

  // The completion cycle right after a fill belongs to the miss, not a new hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      refill_q <= 1'b0;
    end else begin
      if (fill_we)                refill_q <= 1'b1;
      else if (state_q == S_IDLE) refill_q <= 1'b0;
      if (hit_ok && !refill_q && (hits_q != 16'hFFFF)) hits_q <= hits_q + 16'd1;
      if (miss_start && (misses_q != 16'hFFFF)) misses_q <= misses_q + 16'd1;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`else
  assign perf_hits   = '0;
  assign perf_misses = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_assoc.sv
// Bench for cache_assoc (2 ways, 8 sets, 16-byte lines): directed plan plus a
// randomized run checked against a flat-memory + per-set LRU-list model.
`timescale 1ns/1ps
`default_nettype none

module tb_cache_assoc;
  localparam int NW = 2;
  localparam int NS = 8;

  logic         clk = 1'b0;
  logic         reset, mem_read, mem_write, pmem_resp;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address, mem_wdata, mem_rdata, pmem_address, perf_hits, perf_misses;
  logic         mem_resp, pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;

  cache_assoc #(.NUM_WAYS(NW), .NUM_SETS(NS), .LINE_BYTES(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .perf_hits(perf_hits), .perf_misses(perf_misses)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // gold: what the CPU should see; backing: what physical memory holds.
  logic [7:0]  gold    [65536];
  logic [7:0]  backing [65536];
  // Per set: resident line addresses ordered MRU first (two-way tree pLRU is true LRU).
  logic [15:0] m_line  [NS][NW];
  logic        m_dirty [NS][NW];
  int          m_cnt   [NS];
  int          exp_hits, exp_misses;

  function automatic logic [127:0] gold_line(input logic [15:0] base);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = gold[base + 16'(b)];
    return r;
  endfunction

  function automatic logic [127:0] backing_line(input logic [15:0] base);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = backing[base + 16'(b)];
    return r;
  endfunction

  function automatic logic [15:0] gold_word(input logic [15:0] a);
    return {gold[{a[15:1], 1'b1}], gold[{a[15:1], 1'b0}]};
  endfunction

  function automatic int m_find(input int s, input logic [15:0] line);
    for (int i = 0; i < m_cnt[s]; i++) if (m_line[s][i] == line) return i;
    return -1;
  endfunction

  function automatic void m_to_front(input int s, input int i);
    logic [15:0] l = m_line[s][i];
    logic        d = m_dirty[s][i];
    for (int k = i; k > 0; k--) begin
      m_line[s][k]  = m_line[s][k-1];
      m_dirty[s][k] = m_dirty[s][k-1];
    end
    m_line[s][0]  = l;
    m_dirty[s][0] = d;
  endfunction

  function automatic void m_access(input int s, input int i, input logic [15:0] a,
                                   input logic [1:0] be, input logic [15:0] wd, input bit is_wr);
    m_to_front(s, i);
    if (is_wr) begin
      if (be[0]) gold[{a[15:1], 1'b0}] = wd[7:0];
      if (be[1]) gold[{a[15:1], 1'b1}] = wd[15:8];
      if (be != 2'b00) m_dirty[s][0] = 1'b1;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 65536; i++) gold[i] = backing[i];
    for (int s = 0; s < NS; s++) m_cnt[s] = 0;
    exp_hits   = 0;
    exp_misses = 0;
  endfunction

  task automatic pmem_phase(input bit is_wb, input logic [15:0] addr, input logic [127:0] wdata,
                            input int lat, output logic [15:0] seen_addr);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      checks++;
      seen_addr = pmem_address;
      if (is_wb) begin
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || mem_resp !== 1'b0 ||
            pmem_address !== addr || pmem_wdata !== wdata) begin
          errors++;
          $display("FAIL writeback: wr=%b rd=%b addr=%h data=%h, want wr=1 rd=0 addr=%h data=%h",
                   pmem_write, pmem_read, pmem_address, pmem_wdata, addr, wdata);
        end
      end else begin
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || mem_resp !== 1'b0 || pmem_address !== addr) begin
          errors++;
          $display("FAIL fill_req: rd=%b wr=%b resp=%b addr=%h, want rd=1 wr=0 resp=0 addr=%h",
                   pmem_read, pmem_write, mem_resp, pmem_address, addr);
        end
      end
      if (c == lat - 1) begin
        pmem_resp = 1'b1;
        if (!is_wb) pmem_rdata = backing_line(addr);
      end
      @(posedge clk);
      #1 pmem_resp = 1'b0;
    end
  endtask

  // One CPU request, predicted and checked cycle by cycle against the model.
  task automatic run_req(input bit rd, input bit wr, input logic [15:0] a, input logic [1:0] be,
                         input logic [15:0] wd, input int lat, input bit drop,
                         output logic [15:0] rdata_seen, output bit hit_seen,
                         output logic [15:0] wb_seen);
    int          s, hi;
    logic [15:0] line, wb_line, dummy;
    bit          need_wb;
    line       = a & 16'hFFF0;
    s          = int'(a[6:4]);
    hi         = m_find(s, line);
    rdata_seen = '0;
    wb_seen    = '0;
    mem_read = rd; mem_write = wr; mem_address = a; mem_byte_enable = be; mem_wdata = wd;
    @(negedge clk);
    hit_seen = mem_resp;
    if (hi >= 0) begin
      checks++;
      if (mem_resp !== 1'b1 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
        errors++;
        $display("FAIL hit_resp @%h: resp=%b rd=%b wr=%b, want 1 0 0", a, mem_resp, pmem_read, pmem_write);
      end
      if (!wr) begin
        checks++;
        rdata_seen = mem_rdata;
        if (mem_rdata !== gold_word(a)) begin
          errors++;
          $display("FAIL hit_rdata @%h: got %h want %h", a, mem_rdata, gold_word(a));
        end
      end
      m_access(s, hi, a, be, wd, wr);
      exp_hits++;
      @(posedge clk);
      #1 mem_read = 1'b0; mem_write = 1'b0;
    end else begin
      exp_misses++;
      need_wb = 1'b0;
      wb_line = '0;
      if (m_cnt[s] == NW) begin
        need_wb = m_dirty[s][NW-1];
        wb_line = m_line[s][NW-1];
        m_cnt[s]--;
      end
      checks++;
      if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
        errors++;
        $display("FAIL miss_idle @%h: resp=%b rd=%b wr=%b, want 0 0 0", a, mem_resp, pmem_read, pmem_write);
      end
      @(posedge clk);
      #1;
      if (need_wb) begin
        pmem_phase(1'b1, wb_line, gold_line(wb_line), lat, wb_seen);
        for (int b = 0; b < 16; b++) backing[wb_line + 16'(b)] = gold[wb_line + 16'(b)];
      end
      if (drop) begin
        mem_read = 1'b0; mem_write = 1'b0;
      end
      pmem_phase(1'b0, line, '0, lat, dummy);
      m_cnt[s]++;
      m_line[s][m_cnt[s]-1]  = line;
      m_dirty[s][m_cnt[s]-1] = 1'b0;
      @(negedge clk);
      checks++;
      if (drop) begin
        if (mem_resp !== 1'b0) begin
          errors++;
          $display("FAIL dropped_resp @%h: resp=%b want 0", a, mem_resp);
        end
      end else begin
        rdata_seen = mem_rdata;
        if (mem_resp !== 1'b1 || (!wr && mem_rdata !== gold_word(a))) begin
          errors++;
          $display("FAIL miss_done @%h: resp=%b rdata=%h, want resp=1 rdata=%h", a, mem_resp, mem_rdata,
                   wr ? mem_rdata : gold_word(a));
        end
        m_access(s, m_cnt[s] - 1, a, be, wd, wr);
      end
      @(posedge clk);
      #1 mem_read = 1'b0; mem_write = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (mem_resp !== 1'b0 || pmem_read !== 1'b0 || pmem_write !== 1'b0 || mem_rdata !== 16'h0 ||
        pmem_address !== 16'h0 || pmem_wdata !== 128'h0 || perf_hits !== 16'h0 || perf_misses !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: resp=%b rd=%b wr=%b rdata=%h paddr=%h hits=%h misses=%h, want all 0",
               mem_resp, pmem_read, pmem_write, mem_rdata, pmem_address, perf_hits, perf_misses);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_plan();
    logic [15:0] rdv, wbv;
    bit          h;
    do_reset();
    run_req(1, 0, 16'h1234, 2'b11, 16'h0, 2, 0, rdv, h, wbv);
    checks++;
    if (rdv !== 16'hBEEF || h !== 1'b0) begin
      errors++; $display("FAIL cold_read: rdata=%h hit=%b, want BEEF hit=0", rdv, h);
    end
    run_req(1, 0, 16'h1234, 2'b11, 16'h0, 1, 0, rdv, h, wbv);
    checks++;
    if (h !== 1'b1) begin errors++; $display("FAIL reread_hit: hit=%b want 1", h); end
    run_req(0, 1, 16'h1235, 2'b10, 16'hAB00, 1, 0, rdv, h, wbv);
    run_req(1, 0, 16'h1234, 2'b11, 16'h0, 1, 0, rdv, h, wbv);
    checks++;
    if (rdv !== 16'hABEF) begin errors++; $display("FAIL merged_read: rdata=%h want ABEF", rdv); end
    run_req(1, 0, 16'h0034, 2'b11, 16'h0, 3, 0, rdv, h, wbv);
    run_req(1, 0, 16'h2034, 2'b11, 16'h0, 2, 0, rdv, h, wbv);
    checks++;
    if (wbv !== 16'h1230) begin errors++; $display("FAIL evict_addr: wb addr=%h want 1230", wbv); end
    run_req(1, 0, 16'h0034, 2'b11, 16'h0, 1, 0, rdv, h, wbv);
    checks++;
    if (h !== 1'b1) begin errors++; $display("FAIL survivor_hit: hit=%b want 1", h); end
`ifdef CACHE_ASSOC_PERF_CNT_EN
    checks++;
    if (perf_hits !== 16'd4 || perf_misses !== 16'd3) begin
      errors++; $display("FAIL plan_perf: hits=%0d misses=%0d want 4 3", perf_hits, perf_misses);
    end
`endif
  endtask

  task automatic test_reset_mid_fill();
    logic [15:0] rdv, wbv;
    bit          h;
    do_reset();
    mem_read = 1'b1; mem_write = 1'b0; mem_address = 16'h1234; mem_byte_enable = 2'b11;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b1) begin errors++; $display("FAIL fill_started: pmem_read=%b want 1", pmem_read); end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    checks++;
    if (pmem_read !== 1'b0 || mem_resp !== 1'b0) begin
      errors++; $display("FAIL fill_abandon: pmem_read=%b resp=%b want 0 0", pmem_read, mem_resp);
    end
    @(posedge clk);
    #1 m_reset();
    run_req(1, 0, 16'h1234, 2'b11, 16'h0, 1, 0, rdv, h, wbv);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL reread_after_reset: hit=%b want 0", h); end
  endtask

  task automatic test_drop();
    logic [15:0] rdv, wbv;
    bit          h;
    run_req(1, 0, 16'h4008, 2'b11, 16'h0, 2, 1, rdv, h, wbv);
    run_req(1, 0, 16'h4008, 2'b11, 16'h0, 1, 0, rdv, h, wbv);
    checks++;
    if (h !== 1'b1) begin errors++; $display("FAIL drop_fill_kept: hit=%b want 1", h); end
    run_req(0, 1, 16'h5002, 2'b11, 16'h7777, 1, 1, rdv, h, wbv);
    run_req(1, 0, 16'h5002, 2'b11, 16'h0, 1, 0, rdv, h, wbv);
  endtask

  task automatic test_back_to_back();
    logic [15:0] rdv, wbv;
    bit          h;
    for (int i = 0; i < 8; i++)
      run_req(i[0], ~i[0], 16'h4008 + 16'(2 * (i % 4)), 2'b11, 16'(i * 16'h1111), 1, 0, rdv, h, wbv);
  endtask

  task automatic test_random();
    logic [15:0] rdv, wbv, a;
    bit          h, rd, wr, drop;
    int          op;
    for (int n = 0; n < 400; n++) begin
      a  = (n % 7 == 0) ? 16'($urandom) : (16'($urandom_range(0, 3)) << 12) | 16'($urandom & 32'h7F);
      op = $urandom_range(0, 3);
      rd = (op != 2);
      wr = (op >= 2);
      drop = ($urandom_range(0, 15) == 0) && (m_find(int'(a[6:4]), a & 16'hFFF0) < 0);
      run_req(rd, wr, a, 2'($urandom), 16'($urandom), $urandom_range(1, 3), drop, rdv, h, wbv);
    end
  endtask

  task automatic test_perf();
    checks++;
`ifdef CACHE_ASSOC_PERF_CNT_EN
    if (perf_hits !== 16'(exp_hits) || perf_misses !== 16'(exp_misses)) begin
      errors++;
      $display("FAIL perf_counts: hits=%0d misses=%0d want %0d %0d", perf_hits, perf_misses, exp_hits, exp_misses);
    end
`else
    if (perf_hits !== 16'h0 || perf_misses !== 16'h0) begin
      errors++; $display("FAIL perf_tied: hits=%0d misses=%0d want 0 0", perf_hits, perf_misses);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    mem_address = '0; mem_wdata = '0; mem_byte_enable = '0; pmem_rdata = '0;
    for (int i = 0; i < 65536; i++) backing[i] = 8'($urandom);
    backing[16'h1234] = 8'hEF;
    backing[16'h1235] = 8'hBE;
    test_reset();
    test_plan();
    test_reset_mid_fill();
    test_drop();
    test_back_to_back();
    test_random();
    test_perf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
